// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART serial blocks (receiver, transmitter, baud generator).
package spart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned HALF_BIT   = 8;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned SAMPLE_W   = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);

  typedef logic [15:0] divisor_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud divisor and 16x oversample tick generator; tick period is divisor+1 clocks.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter divisor_t DB_RESET = 16'd162
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_dbl,
  input  logic       wr_dbh,
  input  logic [7:0] wr_data,
  output logic       tick
);

  divisor_t divisor;
  divisor_t count;
  logic     reload;

  // A divisor write restarts the count from the new value one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= DB_RESET;
      count   <= DB_RESET;
      reload  <= 1'b0;
    end else begin
      if (wr_dbl) divisor[7:0]  <= wr_data;
      if (wr_dbh) divisor[15:8] <= wr_data;
      reload <= wr_dbl | wr_dbh;
      if (reload || (count == '0)) begin
        count <= divisor;
      end else begin
        count <= count - 16'd1;
      end
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/spart_rx.sv
// SPART receive stage: 16x oversampled 8N1 deserializer with single-byte holding register,
// or a FIFO_DEPTH-entry receive FIFO when SPART_RX_FIFO_EN is defined.
module spart_rx
  import spart_pkg::*;
#(
  parameter divisor_t    DB_RESET    = 16'd162,
  parameter int unsigned SYNC_STAGES = 2
`ifdef SPART_RX_FIFO_EN
  ,
  parameter int unsigned FIFO_DEPTH  = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       wr_dbl,
  input  logic       wr_dbh,
  input  logic [7:0] wr_data,
  input  logic       rd_rx,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       overrun,
  output logic       framing_err
);

  logic                   tick;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  rx_state_t              state;
  logic [SAMPLE_W-1:0]    sample_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shifter;
  logic                   half_tick_c;
  logic                   last_tick_c;
  logic                   commit_c;

  spart_baud_gen #(
    .DB_RESET (DB_RESET)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_dbl  (wr_dbl),
    .wr_dbh  (wr_dbh),
    .wr_data (wr_data),
    .tick    (tick)
  );

  // Metastability synchronizer, reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxs         = sync[SYNC_STAGES-1];
  assign half_tick_c = tick && (sample_cnt == SAMPLE_W'(HALF_BIT - 1));
  assign last_tick_c = tick && (sample_cnt == SAMPLE_W'(OVERSAMPLE - 1));
  assign commit_c    = (state == STOP) && last_tick_c && rxs;

  // Frame FSM: mid-bit sampling at half a bit into START, then every full bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shifter     <= '0;
      framing_err <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state      <= START;
            sample_cnt <= '0;
          end
        end
        START: begin
          if (half_tick_c) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            state      <= rxs ? IDLE : DATA;
          end else if (tick) begin
            sample_cnt <= sample_cnt + SAMPLE_W'(1);
          end
        end
        DATA: begin
          if (last_tick_c) begin
            sample_cnt <= '0;
            shifter    <= {rxs, shifter[DATA_BITS-1:1]};
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else if (tick) begin
            sample_cnt <= sample_cnt + SAMPLE_W'(1);
          end
        end
        STOP: begin
          if (last_tick_c) begin
            sample_cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              framing_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else if (tick) begin
            sample_cnt <= sample_cnt + SAMPLE_W'(1);
          end
        end
        WAIT_HIGH: begin
          // Hold off until the line recovers so a held break does not retrigger.
          if (tick && rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPART_RX_FIFO_EN

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             full_c;
  logic             pop_c;
  logic             push_c;

  assign full_c = (count == CNT_W'(FIFO_DEPTH));
  assign pop_c  = rd_rx && (count != '0);
  assign push_c = commit_c && (!full_c || pop_c);

  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Circular receive FIFO; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rda     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= commit_c && full_c && !pop_c;
      if (push_c) begin
        mem[wr_ptr] <= shifter;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      rda   <= (count_nxt != '0);
    end
  end

  assign rx_data = mem[rd_ptr];

`else

  // Single holding register; a same-cycle read frees the slot before the new byte lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rda     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit_c) begin
        if (!rda || rd_rx) begin
          rx_data <= shifter;
          rda     <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rd_rx) begin
        rda <= 1'b0;
      end
    end
  end

`endif

endmodule
